change_dispenser: RTL and testbench

Coin-return engine that pays out change amounts requested by the vending controller. It accepts an amount in cents over a valid/ready handshake and breaks it into coins greedily: dollar, then quarter, dime, nickel. It drives one hopper at a time and waits for the drop sensor to confirm each coin. It keeps per-denomination inventory and reports each dispensed coin using the controller's 3-bit change code.

---
 rtl/change_dispenser.sv | 185 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-return engine. Breaks a requested amount
// into dollars, quarters, dimes and nickels, fires one hopper at a time,
// waits for the drop sensor and tracks per-denomination inventory.
// Optional feature macro: CHANGE_DISPENSER_DOLLAR_EN enables the dollar
// hopper (index 3); without it the dollar hopper is never loaded or fired.
module change_dispenser #(
   parameter int AMT_W   = 8,
   parameter int INV_W   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req_valid,
   input  logic [AMT_W-1:0] i_req_amount,
   output logic             o_req_ready,
   output logic [3:0]       o_hop_fire,
   input  logic             i_hop_ack,
   output logic [2:0]       o_change,
   output logic             o_change_valid,
   output logic             o_done,
   output logic             o_short,
   output logic [AMT_W-1:0] o_remaining,
   output logic             o_fault,
   input  logic             i_inv_load,
   input  logic [1:0]       i_inv_sel,
   input  logic [INV_W-1:0] i_inv_count,
   output logic [INV_W-1:0] o_inv_rd
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

`ifdef CHANGE_DISPENSER_DOLLAR_EN
   localparam logic DOLLAR_EN = 1'b1;
`else
   localparam logic DOLLAR_EN = 1'b0;
`endif

   // dollar drive bit is forced low when the dollar hopper is absent
   localparam logic [3:0] FIRE_MASK = {DOLLAR_EN, 3'b111};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECT   = 2'd1,
      WAIT_ACK = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [AMT_W-1:0]        r_rem;
   logic [3:0][INV_W-1:0]   r_inv;
   logic [1:0]              r_coin;
   logic [TMR_W-1:0]        r_tmr;
   logic [3:0]              r_hop_fire;
   logic [2:0]              r_change;
   logic                    r_change_valid;
   logic                    r_done;
   logic                    r_short;
   logic [AMT_W-1:0]        r_remaining;
   logic                    r_fault;

   logic [3:0]              w_coin_ok;
   logic                    w_found;
   logic [1:0]              w_pick;
   logic                    w_ack;
   logic                    w_expire;

   // coin value in cents by hopper index
   function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] idx);
      case (idx)
         2'd0:    coin_val = AMT_W'(5);
         2'd1:    coin_val = AMT_W'(10);
         2'd2:    coin_val = AMT_W'(25);
         default: coin_val = AMT_W'(100);
      endcase
   endfunction

   // a coin is eligible when it fits in the remainder and its hopper is stocked
   for (genvar g = 0; g < 4; g++) begin : g_coin
      assign w_coin_ok[g] = (r_inv[g] != '0) && (r_rem >= coin_val(2'(g))) &&
                            ((g != 3) || DOLLAR_EN);
   end

   // greedy pick: ascending scan so the largest eligible coin wins
   always_comb begin
      w_found = 1'b0;
      w_pick  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (w_coin_ok[i]) begin
            w_found = 1'b1;
            w_pick  = 2'(i);
         end
      end
   end

   // ack beats expiry on the same cycle
   assign w_ack    = (r_state == WAIT_ACK) && i_hop_ack;
   assign w_expire = (r_state == WAIT_ACK) && !i_hop_ack &&
                     (r_tmr == TMR_W'(TIMEOUT - 1));

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (i_req_valid) w_state_nxt = SELECT;
         SELECT:   w_state_nxt = w_found ? WAIT_ACK : DONE;
         WAIT_ACK: if (w_ack || w_expire) w_state_nxt = SELECT;
         DONE:     w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // datapath: remainder, inventory, hopper drive, timer and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem          <= '0;
         r_inv          <= '0;
         r_coin         <= 2'd0;
         r_tmr          <= '0;
         r_hop_fire     <= 4'd0;
         r_change       <= 3'd0;
         r_change_valid <= 1'b0;
         r_done         <= 1'b0;
         r_short        <= 1'b0;
         r_remaining    <= '0;
         r_fault        <= 1'b0;
      end else begin
         r_change       <= 3'd0;
         r_change_valid <= 1'b0;
         r_done         <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_req_valid) r_rem <= i_req_amount;
               if (i_inv_load && ((i_inv_sel != 2'd3) || DOLLAR_EN))
                  r_inv[i_inv_sel] <= i_inv_count;
            end
            SELECT: begin
               r_tmr <= '0;
               if (w_found) begin
                  r_coin     <= w_pick;
                  r_hop_fire <= 4'b0001 << w_pick;
               end else begin
                  r_done      <= 1'b1;
                  r_short     <= (r_rem != '0);
                  r_remaining <= r_rem;
               end
            end
            WAIT_ACK: begin
               if (w_ack) begin
                  r_hop_fire     <= 4'd0;
                  r_rem          <= r_rem - coin_val(r_coin);
                  r_inv[r_coin]  <= r_inv[r_coin] - INV_W'(1);
                  r_change_valid <= 1'b1;
                  r_change       <= {1'b0, r_coin} + 3'd1;
               end else if (w_expire) begin
                  // jammed or empty hopper: retire it and fall back to smaller coins
                  r_hop_fire    <= 4'd0;
                  r_inv[r_coin] <= '0;
                  r_fault       <= 1'b1;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_req_ready    = (r_state == IDLE);
   assign o_hop_fire     = r_hop_fire & FIRE_MASK;
   assign o_change       = r_change;
   assign o_change_valid = r_change_valid;
   assign o_done         = r_done;
   assign o_short        = r_short;
   assign o_remaining    = r_remaining;
   assign o_fault        = r_fault;
   assign o_inv_rd       = ((i_inv_sel == 2'd3) && !DOLLAR_EN) ? '0 : r_inv[i_inv_sel];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scripted hopper environment plus a coin-level model of
// the dispenser; a single negedge process compares every output each cycle.
`timescale 1ns/1ps
module tb_change_dispenser;
   localparam int TIMEOUT = 1023;
`ifdef CHANGE_DISPENSER_DOLLAR_EN
   localparam bit DOLLAR = 1'b1;
`else
   localparam bit DOLLAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_req_valid = 1'b0;
   logic [7:0] i_req_amount = 8'd0;
   logic       o_req_ready;
   logic [3:0] o_hop_fire;
   logic       i_hop_ack = 1'b0;
   logic [2:0] o_change;
   logic       o_change_valid, o_done, o_short, o_fault;
   logic [7:0] o_remaining;
   logic       i_inv_load = 1'b0;
   logic [1:0] i_inv_sel = 2'd0;
   logic [7:0] i_inv_count = 8'd0;
   logic [7:0] o_inv_rd;

   change_dispenser #(.AMT_W(8), .INV_W(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_amount(i_req_amount), .o_req_ready(o_req_ready),
      .o_hop_fire(o_hop_fire), .i_hop_ack(i_hop_ack),
      .o_change(o_change), .o_change_valid(o_change_valid),
      .o_done(o_done), .o_short(o_short), .o_remaining(o_remaining), .o_fault(o_fault),
      .i_inv_load(i_inv_load), .i_inv_sel(i_inv_sel), .i_inv_count(i_inv_count),
      .o_inv_rd(o_inv_rd)
   );

   always #5 clk = ~clk;

   // model state and per-cycle expectations
   int         m_inv[4];
   int         pays[$];
   int         last_short, last_rem;
   logic       chk_en = 1'b0;
   logic [3:0] e_fire = 4'd0;
   logic [2:0] e_change = 3'd0;
   logic       e_ready = 1'b1, e_cv = 1'b0, e_done = 1'b0, e_short = 1'b0, e_fault = 1'b0;
   int         e_rem = 0;
   int         errors = 0, checks = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int val(input int i);
      case (i)
         0: return 5;
         1: return 10;
         2: return 25;
         default: return 100;
      endcase
   endfunction

   // largest stocked coin not exceeding rem, or -1
   function automatic int pick(input int rem);
      for (int i = 3; i >= 0; i--)
         if ((i < 3 || DOLLAR) && m_inv[i] > 0 && rem >= val(i)) return i;
      return -1;
   endfunction

   // every-cycle output check
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", o_req_ready, e_ready);
         chk("hop_fire", o_hop_fire, e_fire);
         chk("change_valid", o_change_valid, e_cv);
         chk("change", o_change, e_change);
         chk("done", o_done, e_done);
         chk("fault", o_fault, e_fault);
         chk("inv_rd", o_inv_rd, m_inv[i_inv_sel]);
         if (e_done) begin
            chk("short", o_short, e_short);
            chk("remaining", o_remaining, e_rem);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      i_hop_ack   = 1'b0;
      i_inv_load  = 1'b0;
      i_inv_sel   = 2'($urandom_range(0, 3));
      i_inv_count = 8'($urandom);
   endtask

   // stray inputs the DUT must ignore in the current (non-IDLE) state
   task automatic noise(input bit ack_ok);
      if (ack_ok && $urandom_range(0, 3) == 0) i_hop_ack = 1'b1;
      if ($urandom_range(0, 3) == 0) i_inv_load = 1'b1;
   endtask

   task automatic exp_idle();
      e_ready = 1'b1; e_fire = 4'd0; e_cv = 1'b0; e_change = 3'd0; e_done = 1'b0;
   endtask

   task automatic idle_cycle();
      exp_idle();
      if ($urandom_range(0, 2) == 0) i_hop_ack = 1'b1;
      tick();
   endtask

   task automatic load(input int sel, input int cnt);
      exp_idle();
      i_inv_load = 1'b1; i_inv_sel = 2'(sel); i_inv_count = 8'(cnt);
      tick();
      if (sel < 3 || DOLLAR) m_inv[sel] = cnt;
   endtask

   task automatic do_req(input int amt, input logic [3:0] jam, input bit abort);
      int rem, p, d;
      pays.delete();
      exp_idle();
      i_req_valid = 1'b1; i_req_amount = 8'(amt);
      if ($urandom_range(0, 3) == 0) i_hop_ack = 1'b1;
      tick();
      rem = amt;
      // SELECT
      exp_idle(); e_ready = 1'b0; noise(1);
      tick();
      forever begin
         e_cv = 1'b0; e_change = 3'd0; e_ready = 1'b0;
         p = pick(rem);
         if (p < 0) begin
            e_done = 1'b1; e_short = (rem != 0); e_rem = rem;
            last_short = (rem != 0); last_rem = rem;
            noise(1);
            tick();
            exp_idle();
            return;
         end
         e_fire = 4'(1 << p);
         if (abort) begin
            reset = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) m_inv[i] = 0;
            exp_idle(); e_fault = 1'b0;
            reset = 1'b0;
            tick();
            return;
         end
         if (jam[p]) begin
            for (int c = 0; c < TIMEOUT; c++) begin noise(0); tick(); end
            m_inv[p] = 0; e_fault = 1'b1; e_fire = 4'd0;
            noise(1);
            tick();
         end else begin
            d = ($urandom_range(0, 19) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin noise(0); tick(); end
            i_hop_ack = 1'b1;
            tick();
            rem -= val(p); m_inv[p]--; pays.push_back(p + 1);
            e_fire = 4'd0; e_cv = 1'b1; e_change = 3'(p + 1);
            noise(1);
            tick();
         end
      end
   endtask

   task automatic lit_inv(input string nm, input int sel, input int exp);
      i_inv_sel = 2'(sel); #1;
      chk(nm, o_inv_rd, exp);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_inv[i] = 0;
      reset = 1'b1;
      tick(); tick();
      exp_idle(); e_fault = 1'b0;
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // 40 cents from a fully stocked machine
      for (int s = 0; s < 4; s++) load(s, 10);
      do_req(40, 4'd0, 1'b0);
      chk("tc1_npay", pays.size(), 3);
      if (pays.size() == 3) begin
         chk("tc1_pay0", pays[0], 3); chk("tc1_pay1", pays[1], 2); chk("tc1_pay2", pays[2], 1);
      end
      chk("tc1_short", last_short, 0);
      lit_inv("tc1_inv_n", 0, 9); lit_inv("tc1_inv_d", 1, 9); lit_inv("tc1_inv_q", 2, 9);
      lit_inv("tc1_inv_dollar", 3, DOLLAR ? 10 : 0);
      idle_cycle();

      // quarters empty: 50 cents in dimes
      load(2, 0); load(3, 0); load(1, 10);
      do_req(50, 4'd0, 1'b0);
      chk("tc2_npay", pays.size(), 5);
      foreach (pays[i]) chk("tc2_code", pays[i], 2);
      chk("tc2_short", last_short, 0);

      // only two nickels for 35 cents
      load(1, 0); load(0, 2);
      do_req(35, 4'd0, 1'b0);
      chk("tc3_npay", pays.size(), 2);
      chk("tc3_short", last_short, 1);
      chk("tc3_rem", last_rem, 25);

      // quarter hopper jams
      load(0, 5); load(1, 5); load(2, 5);
      do_req(25, 4'b0100, 1'b0);
      chk("tc4_npay", pays.size(), 3);
      if (pays.size() == 3) begin
         chk("tc4_pay0", pays[0], 2); chk("tc4_pay1", pays[1], 2); chk("tc4_pay2", pays[2], 1);
      end
      chk("tc4_fault", o_fault, 1);
      lit_inv("tc4_inv_q", 2, 0);

      // zero request and a non-multiple of five
      do_req(0, 4'd0, 1'b0);
      chk("tc5_npay0", pays.size(), 0);
      chk("tc5_short0", last_short, 0);
      do_req(7, 4'd0, 1'b0);
      chk("tc5_npay7", pays.size(), 1);
      chk("tc5_short7", last_short, 1);
      chk("tc5_rem7", last_rem, 2);

      // randomized traffic
      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) load($urandom_range(0, 3), $urandom_range(0, 6));
         do_req($urandom_range(0, 255),
                ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0, 1'b0);
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) idle_cycle();
      end

      // reset while a hopper is firing
      load(0, 3); load(1, 3); load(2, 3);
      do_req(30, 4'd0, 1'b1);
      chk("tc6_ready", o_req_ready, 1);
      chk("tc6_fault", o_fault, 0);
      lit_inv("tc6_inv_q", 2, 0);
      idle_cycle();
      load(1, 4);
      do_req(20, 4'd0, 1'b0);
      chk("tc6_npay", pays.size(), 2);
      idle_cycle();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
